// File: rtl/pll_freq_synth.sv
// One PLL output path: measures the ref_in period in clk cycles, qualifies it as stable,
// then synthesizes out at f_ref*M/(D*O) with a phase accumulator running on clk.
module pll_freq_synth #(
    parameter int M            = 5,
    parameter int D            = 1,
    parameter int O            = 1,
    parameter int STABLE_COUNT = 4,
    parameter int TOL          = 1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        PWRDWN,
    input  logic        ref_in,
    output logic [31:0] period_length,
    output logic        period_stable,
    output logic [31:0] out_period_length_1000,
    output logic        out,
    output logic        locked
);

    localparam logic [63:0] SCALE    = 64'(D * O * 1000);
    localparam logic [7:0]  DIVISOR  = 8'(M);
    localparam logic [31:0] TOL_C    = 32'(TOL);
    localparam logic [7:0]  STABLE_C = 8'(STABLE_COUNT);
    localparam logic [32:0] STEP     = 33'd1000;

    typedef enum logic [2:0] {S_IDLE, S_DIV, S_LOAD, S_ARM, S_RUN} state_t;

    logic clr;
    assign clr = RST | PWRDWN;

    // ---------------- period count and check ----------------
    logic        ref_s1_q, ref_s2_q, ref_prev_q, seen_edge_q;
    logic [31:0] counter_q, counter_d;
    logic [31:0] period_q, period_d;
    logic [7:0]  match_q, match_d;
    logic        stable_q, stable_d;
    logic        ref_rise, in_tol, timeout;
    logic [31:0] delta;

    always_comb begin
        ref_rise  = ref_s2_q & ~ref_prev_q;
        delta     = (counter_q >= period_q) ? (counter_q - period_q) : (period_q - counter_q);
        in_tol    = (delta <= TOL_C);
        timeout   = stable_q && ({1'b0, counter_q} > {period_q, 1'b0});
        counter_d = (counter_q == 32'hFFFF_FFFF) ? counter_q : counter_q + 32'd1;
        period_d  = period_q;
        match_d   = match_q;
        stable_d  = stable_q;
        if (ref_rise) begin
            counter_d = 32'd1;
            // The very first edge only opens the measurement window.
            if (seen_edge_q) begin
                period_d = counter_q;
                if (!in_tol) begin
                    match_d = '0;
                end else if (match_q < STABLE_C) begin
                    match_d = match_q + 8'd1;
                end
                stable_d = (match_d >= STABLE_C);
            end
        end else if (timeout) begin
            stable_d = 1'b0;
            match_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ref_s1_q    <= 1'b0;
            ref_s2_q    <= 1'b0;
            ref_prev_q  <= 1'b0;
            seen_edge_q <= 1'b0;
            counter_q   <= '0;
            period_q    <= '0;
            match_q     <= '0;
            stable_q    <= 1'b0;
        end else begin
            ref_s1_q    <= ref_in;
            ref_s2_q    <= ref_s1_q;
            ref_prev_q  <= ref_s2_q;
            seen_edge_q <= seen_edge_q | ref_rise;
            counter_q   <= counter_d;
            period_q    <= period_d;
            match_q     <= match_d;
            stable_q    <= stable_d;
        end
    end

    // ---------------- divider and phase accumulator ----------------
    state_t      state_q, state_d;
    logic [63:0] dividend_q, dividend_d;
    logic [63:0] quo_q, quo_d;
    logic [6:0]  rem_q, rem_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] olp_q, olp_d;
    logic [31:0] half_q, half_d;
    logic [31:0] acc_q, acc_d;
    logic        out_q, out_d;
    logic        locked_q, locked_d;
    logic [7:0]  rem_shift;
    logic        rem_ge;
    logic [32:0] sum;

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        bit_cnt_d  = bit_cnt_q;
        olp_d      = olp_q;
        half_d     = half_q;
        acc_d      = acc_q;
        out_d      = out_q;
        locked_d   = locked_q;
        rem_shift  = {rem_q, dividend_q[63]};
        rem_ge     = (rem_shift >= DIVISOR);
        sum        = {1'b0, acc_q} + STEP;

        case (state_q)
            S_IDLE: begin
                if (stable_d && !stable_q) begin
                    dividend_d = 64'(period_d) * SCALE;
                    quo_d      = '0;
                    rem_d      = '0;
                    bit_cnt_d  = 6'd63;
                    state_d    = S_DIV;
                end
            end
            S_DIV: begin
                // Restoring division, one quotient bit per clk, MSB first.
                rem_d      = rem_ge ? 7'(rem_shift - DIVISOR) : rem_shift[6:0];
                quo_d      = {quo_q[62:0], rem_ge};
                dividend_d = {dividend_q[62:0], 1'b0};
                bit_cnt_d  = bit_cnt_q - 6'd1;
                if (bit_cnt_q == 6'd0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                olp_d   = (quo_q[63:32] != 32'd0) ? 32'hFFFF_FFFF : quo_q[31:0];
                half_d  = {1'b0, olp_d[31:1]};
                acc_d   = '0;
                out_d   = 1'b0;
                state_d = S_ARM;
            end
            S_ARM: begin
                // A zero half period means ref is too fast to synthesize; stay unlocked.
                locked_d = (half_q != 32'd0);
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (locked_q) begin
                    if (half_q < 32'd1000) begin
                        acc_d = '0;
                        out_d = ~out_q;
                    end else if (sum >= {1'b0, half_q}) begin
                        acc_d = 32'(sum - {1'b0, half_q});
                        out_d = ~out_q;
                    end else begin
                        acc_d = sum[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Losing stability aborts any computation and silences the output; P holds.
        if (!stable_d) begin
            state_d  = S_IDLE;
            locked_d = 1'b0;
            out_d    = 1'b0;
            acc_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            dividend_q <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            bit_cnt_q  <= '0;
            olp_q      <= '0;
            half_q     <= '0;
            acc_q      <= '0;
            out_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            bit_cnt_q  <= bit_cnt_d;
            olp_q      <= olp_d;
            half_q     <= half_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            locked_q   <= locked_d;
        end
    end

    assign period_length          = period_q;
    assign period_stable          = stable_q;
    assign out_period_length_1000 = olp_q;
    assign out                    = out_q;
    assign locked                 = locked_q;

endmodule

// File: tb/tb_pll_freq_synth.sv
// Bench for pll_freq_synth: two instances (M=5,D=1,O=1 and M=2,D=1,O=4) share one
// reference; status transitions are scored against hand-computed expected records.
module tb_pll_freq_synth;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic RST, PWRDWN, ref_in;
    always #5 clk = ~clk;

    logic [31:0] pl_a, olp_a, pl_b, olp_b;
    logic        stable_a, out_a, locked_a, stable_b, out_b, locked_b;

    pll_freq_synth #(.M(5), .D(1), .O(1), .STABLE_COUNT(4), .TOL(1)) dut_a (
        .clk(clk), .RST(RST), .PWRDWN(PWRDWN), .ref_in(ref_in),
        .period_length(pl_a), .period_stable(stable_a),
        .out_period_length_1000(olp_a), .out(out_a), .locked(locked_a));

    pll_freq_synth #(.M(2), .D(1), .O(4), .STABLE_COUNT(4), .TOL(1)) dut_b (
        .clk(clk), .RST(RST), .PWRDWN(PWRDWN), .ref_in(ref_in),
        .period_length(pl_b), .period_stable(stable_b),
        .out_period_length_1000(olp_b), .out(out_b), .locked(locked_b));

    // ---------------- scoreboard ----------------
    // Record layout: {period_stable, locked, period_length, out_period_length_1000}
    int checks = 0;
    int errors = 0;
    logic [65:0] exp_a_q[$];
    logic [65:0] exp_b_q[$];
    logic        mon_en = 1'b0;
    logic [1:0]  prev_a = 2'b00;
    logic [1:0]  prev_b = 2'b00;
    int          lat_a = 0;
    logic        lat_run = 1'b0;

    function automatic logic [65:0] rec(logic s, logic l, logic [31:0] pl, logic [31:0] op);
        return {s, l, pl, op};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every change of {period_stable, locked} pops one expected record.
    always @(negedge clk) begin
        logic [65:0] cur_a, cur_b, e;
        if (mon_en) begin
            cur_a = {stable_a, locked_a, pl_a, olp_a};
            cur_b = {stable_b, locked_b, pl_b, olp_b};
            if (cur_a[65] && !prev_a[1]) begin
                lat_a   = 0;
                lat_run = 1'b1;
            end else if (lat_run) begin
                lat_a++;
            end
            if (cur_a[64] && !prev_a[0] && lat_run) begin
                lat_run = 1'b0;
                checks++;
                if (lat_a > 71) begin
                    errors++;
                    $display("FAIL lock_latency actual=%0d required<=71", lat_a);
                end
            end
            if (cur_a[65:64] != prev_a) begin
                if (exp_a_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_event actual=%0h required=none", cur_a);
                end else begin
                    e = exp_a_q.pop_front();
                    check("a_event", cur_a, e);
                end
            end
            if (cur_b[65:64] != prev_b) begin
                if (exp_b_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_event actual=%0h required=none", cur_b);
                end else begin
                    e = exp_b_q.pop_front();
                    check("b_event", cur_b, e);
                end
            end
            prev_a = cur_a[65:64];
            prev_b = cur_b[65:64];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic ref_period(input int hi, input int lo);
        ref_in = 1'b1;
        repeat (hi) @(negedge clk);
        ref_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        #1;
        check(name, 66'(exp_a_q.size() + exp_b_q.size()), 66'd0);
    endtask

    task automatic run_until_drained(input int max_periods, input string name);
        int n = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < max_periods) begin
            ref_period(5, 5);
            n++;
        end
        check_drained(name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_a_status"}, 66'({stable_a, locked_a, out_a}), 66'd0);
        check({name, "_a_values"}, 66'({pl_a, olp_a}), 66'd0);
        check({name, "_b_status"}, 66'({stable_b, locked_b, out_b, pl_b, olp_b}), 66'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        RST    = 1'b1;
        PWRDWN = 1'b0;
        ref_in = 1'b0;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        check_all_zero("reset");
        mon_en = 1'b1;

        // T1/T2: period 10 -> A: P=10*1000/5=2000; B: P=10*4*1000/2=20000
        exp_a_q.push_back(rec(1'b1, 1'b0, 32'd10, 32'd0));
        exp_a_q.push_back(rec(1'b1, 1'b1, 32'd10, 32'd2000));
        exp_b_q.push_back(rec(1'b1, 1'b0, 32'd10, 32'd0));
        exp_b_q.push_back(rec(1'b1, 1'b1, 32'd10, 32'd20000));
        run_until_drained(20, "t1_lock_drain");
        fork
            begin
                repeat (10) ref_period(5, 5);
            end
            begin
                logic exp_out;
                int   n, hi_len, lo_len;
                exp_out = out_a;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    exp_out = ~exp_out;
                    check("t1_out_toggle", 66'(out_a), 66'(exp_out));
                end
                n = 0;
                while (out_b !== 1'b0 && n < 25) begin @(negedge clk); n++; end
                while (out_b !== 1'b1 && n < 50) begin @(negedge clk); n++; end
                hi_len = 0;
                while (out_b === 1'b1 && hi_len < 25) begin @(negedge clk); hi_len++; end
                lo_len = 0;
                while (out_b === 1'b0 && lo_len < 25) begin @(negedge clk); lo_len++; end
                check("t2_out_high_len", 66'(hi_len), 66'd10);
                check("t2_out_low_len", 66'(lo_len), 66'd10);
            end
        join

        // T5: one-cycle RST while locked
        exp_a_q.push_back(rec(1'b0, 1'b0, 32'd0, 32'd0));
        exp_b_q.push_back(rec(1'b0, 1'b0, 32'd0, 32'd0));
        fork
            ref_period(5, 5);
            begin
                repeat (7) @(negedge clk);
                RST = 1'b1;
                @(negedge clk);
                RST = 1'b0;
                check_all_zero("t5_after_rst");
            end
        join
        check_drained("t5_drain");

        // T3: first edge, then periods 10,10,11,10,10,10,10; later a 13 drops stability
        exp_a_q.push_back(rec(1'b1, 1'b0, 32'd10, 32'd0));
        exp_a_q.push_back(rec(1'b1, 1'b1, 32'd10, 32'd2000));
        exp_b_q.push_back(rec(1'b1, 1'b0, 32'd10, 32'd0));
        exp_b_q.push_back(rec(1'b1, 1'b1, 32'd10, 32'd20000));
        ref_period(5, 5);
        ref_period(5, 5);
        ref_period(5, 6);
        repeat (5) ref_period(5, 5);
        run_until_drained(15, "t3_lock_drain");
        exp_a_q.push_back(rec(1'b0, 1'b0, 32'd13, 32'd2000));
        exp_b_q.push_back(rec(1'b0, 1'b0, 32'd13, 32'd20000));
        ref_period(5, 8);
        ref_period(5, 5);
        check_drained("t3_drop_drain");

        // T4: relock (P held from before), then ref stuck high -> timeout
        exp_a_q.push_back(rec(1'b1, 1'b0, 32'd10, 32'd2000));
        exp_a_q.push_back(rec(1'b1, 1'b1, 32'd10, 32'd2000));
        exp_b_q.push_back(rec(1'b1, 1'b0, 32'd10, 32'd20000));
        exp_b_q.push_back(rec(1'b1, 1'b1, 32'd10, 32'd20000));
        run_until_drained(20, "t4_relock_drain");
        exp_a_q.push_back(rec(1'b0, 1'b0, 32'd10, 32'd2000));
        exp_b_q.push_back(rec(1'b0, 1'b0, 32'd10, 32'd20000));
        ref_in = 1'b1;
        repeat (15) @(negedge clk);
        check("t4_stable_before_timeout", 66'(stable_a), 66'd1);
        for (int i = 0; i < 30 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++) begin
            @(negedge clk);
        end
        check_drained("t4_timeout_drain");

        // T6: PWRDWN for 50 clk with ref running
        PWRDWN = 1'b1;
        for (int i = 0; i < 50; i++) begin
            ref_in = ((i % 10) < 5);
            @(negedge clk);
            check_all_zero("t6_pwrdwn");
        end
        PWRDWN = 1'b0;
        exp_a_q.push_back(rec(1'b1, 1'b0, 32'd10, 32'd0));
        exp_a_q.push_back(rec(1'b1, 1'b1, 32'd10, 32'd2000));
        exp_b_q.push_back(rec(1'b1, 1'b0, 32'd10, 32'd0));
        exp_b_q.push_back(rec(1'b1, 1'b1, 32'd10, 32'd20000));
        run_until_drained(20, "t6_relock_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
